// File: rtl/wb_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : wb_mtimer
// Purpose  : Wishbone machine timer with a 64-bit mtime counter, mtimecmp,
//            a coherent LO/HI read shadow and a level interrupt.
//            Optional prescaler enabled by defining WB_MTIMER_PRESCALER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mtimer #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dev_sel,
    input  logic [9:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_cyc,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam logic [9:0] c_adr_mtime_lo = 10'h000;
    localparam logic [9:0] c_adr_mtime_hi = 10'h001;
    localparam logic [9:0] c_adr_cmp_lo   = 10'h002;
    localparam logic [9:0] c_adr_cmp_hi   = 10'h003;
    localparam logic [9:0] c_adr_ctrl     = 10'h004;
    localparam logic [9:0] c_adr_prescale = 10'h005;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_shadow;
    logic        r_en;
    logic        r_ie;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_irq;

    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic [31:0] w_rdata;
    logic [31:0] w_prescale_rd;

    // Register read paths assume the divisor fits one bus word.
    if (PRESCALE_WIDTH < 1 || PRESCALE_WIDTH > 32) begin : g_prescale_width_invalid
    end

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) result[8*b +: 8] = new_val[8*b +: 8];
        end
        return result;
    endfunction

    assign w_accept = i_dev_sel & i_wb_cyc & ~r_ack;
    assign w_wr     = w_accept & i_wb_we;
    assign w_rd     = w_accept & ~i_wb_we;

`ifdef WB_MTIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_pcnt;
    logic                      w_prescale_wr;

    assign w_prescale_wr = w_wr & (i_wb_adr == c_adr_prescale);
    assign w_tick        = r_en & (r_pcnt == r_prescale);
    assign w_prescale_rd = 32'(r_prescale);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            if (w_prescale_wr) begin
                for (int i = 0; i < PRESCALE_WIDTH; i++) begin
                    if (i_wb_sel[i/8]) r_prescale[i] <= i_wb_dat[i];
                end
            end
            // Counter restarts on reprogramming, while disabled, and after each tick.
            if (w_prescale_wr || !r_en || w_tick) r_pcnt <= '0;
            else                                  r_pcnt <= r_pcnt + 1'b1;
        end
    end
`else
    assign w_tick        = r_en;
    assign w_prescale_rd = '0;
`endif

    always_comb begin
        w_rdata = '0;
        case (i_wb_adr)
            c_adr_mtime_lo: w_rdata = r_mtime[31:0];
            c_adr_mtime_hi: w_rdata = r_shadow;
            c_adr_cmp_lo:   w_rdata = r_mtimecmp[31:0];
            c_adr_cmp_hi:   w_rdata = r_mtimecmp[63:32];
            c_adr_ctrl:     w_rdata = {30'b0, r_ie, r_en};
            c_adr_prescale: w_rdata = w_prescale_rd;
            default:        w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_shadow   <= '0;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ack <= w_accept;
            r_dat <= w_rd ? w_rdata : '0;
            r_irq <= r_ie & (r_mtime >= r_mtimecmp);

            if (w_rd && (i_wb_adr == c_adr_mtime_lo)) r_shadow <= r_mtime[63:32];

            // A bus write to either half wins over the tick in the same cycle.
            if (w_wr && (i_wb_adr == c_adr_mtime_lo))
                r_mtime <= {r_mtime[63:32], f_merge(r_mtime[31:0], i_wb_dat, i_wb_sel)};
            else if (w_wr && (i_wb_adr == c_adr_mtime_hi))
                r_mtime <= {f_merge(r_mtime[63:32], i_wb_dat, i_wb_sel), r_mtime[31:0]};
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;

            if (w_wr && (i_wb_adr == c_adr_cmp_lo))
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], i_wb_dat, i_wb_sel);
            if (w_wr && (i_wb_adr == c_adr_cmp_hi))
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], i_wb_dat, i_wb_sel);

            if (w_wr && (i_wb_adr == c_adr_ctrl) && i_wb_sel[0]) begin
                r_en <= i_wb_dat[0];
                r_ie <= i_wb_dat[1];
            end
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_dat = r_dat;
    assign o_irq    = r_irq;

endmodule
`default_nettype wire
